rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
//   Read-side master for the synchronous ROM (registered data_out, 1-cycle latency, holds when en=0).
//   On start, reads `length` consecutive words from base_addr, wrapping modulo 2^ADDR_W.
//   Delivers them in order on a valid/ready stream; downstream backpressure never drops or duplicates a word.
//   Sits between the ROM and any consumer (display, pattern generator, serialiser).
// PARAMETERS
//   ADDR_W  3  ROM address width; address wraps modulo 2^ADDR_W
//   DATA_W  8  ROM / output data width
//   LEN_W   4  width of burst length; max burst = 2^LEN_W-1 words
// PORTS
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       burst request, sampled only in IDLE
//   base_addr    in   ADDR_W  first ROM address, captured with start
//   length       in   LEN_W   words to read, captured with start
//   busy         out  1       high from cycle after accepted start until done
//   done         out  1       one-cycle pulse at burst completion
//   address      out  ADDR_W  ROM address
//   en           out  1       ROM read enable
//   rom_data     in   DATA_W  ROM data_out
//   out_data     out  DATA_W  stream data
//   out_valid    out  1       stream valid
//   out_ready    in   1       stream ready
// BEHAVIOUR
//   Reset:
//     - All outputs 0; FSM to IDLE; 2-entry output FIFO emptied; inflight flag cleared.
//     - Takes effect immediately, mid-burst included; no partial data survives.
//   FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//     - IDLE: start=1 captures base_addr/length and issue_cnt=0.
//       length!=0 -> ISSUE; length==0 -> IDLE with done=1 next cycle, no en pulse.
//       start is ignored outside IDLE.
//     - ISSUE: en=1 and address=base_addr+issue_cnt (mod 2^ADDR_W) when credit holds.
//       Credit: (fifo_cnt + inflight) < 2, OR (out_valid && out_ready) this cycle.
//       issue_cnt increments per issued read; last issue -> DRAIN.
//     - DRAIN: en=0. When fifo_cnt==0, inflight==0 and the final word is handshaken:
//       -> IDLE, done=1 and busy=0 in the next cycle.
//   Capture:
//     - inflight <= en each cycle.
//     - While inflight=1, rom_data is pushed into the FIFO that cycle; never sampled otherwise.
//   Stream:
//     - out_valid = fifo_cnt!=0; out_data = FIFO head.
//     - out_data holds stable while out_valid && !out_ready; pop on out_valid && out_ready.
//     - FIFO depth 2 is sufficient by the credit rule; push and pop in one cycle keep fifo_cnt.
//   Timing (start sampled at edge 0):
//     - en first high in cycle 1; first out_valid in cycle 3.
//     - With out_ready=1, one word per cycle, no bubbles.
//   Arithmetic:
//     - Address add truncated to ADDR_W.
//     - issue_cnt and deliver_cnt are LEN_W bits and are compared to the captured length.
// TESTING
//   ROM model: word[a] = a+1.
//   - base=0, len=8, out_ready=1: out_data 1..8 in cycles 3..10; done pulse in cycle 11; en high in cycles 1..8.
//   - base=6, len=4: address 6,7,0,1; out_data 7,8,1,2 (wrap).
//   - base=0, len=8, out_ready=0 from start: exactly 2 en pulses; out_data held at 1.
//     Release out_ready at cycle 10: 1..8 delivered once each, in order.
//   - len=0: no en pulse, no out_valid; done high in cycle 1 only.
//   - rst_n low during cycle 4 of an 8-word burst: all outputs 0 immediately.
//     A new start after release reads fresh data from base.
//   - start re-asserted while busy: ignored; burst count unchanged.

Source files
------------

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst read master for a 1-cycle-latency synchronous ROM
//
// Reads `length` consecutive ROM words starting at base_addr. The address wraps
// modulo 2^ADDR_W. The words are delivered in order on a valid/ready stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               burst request, sampled only in IDLE
//   base_addr_i           first ROM address (captured with start)
//   length_i              number of words (captured with start), 0 allowed
//   busy_o                burst in progress
//   done_o                one-cycle pulse after the burst completes
//   address_o, en_o       ROM read port
//   rom_data_i            ROM registered data_out
//   out_data_o            stream data
//   out_valid_o           stream valid
//   out_ready_i           stream ready
module rom_burst_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              en_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]    deliver_cnt_q, deliver_cnt_d;
    logic                done_q, done_d;
    logic                inflight_q;

    logic [DATA_W-1:0]   fifo_mem_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fifo_cnt_q;

    logic                push, pop, credit, issue;
    logic [2:0]          occupancy;
    logic [ADDR_W+LEN_W-1:0] addr_sum;

    // A read issued in cycle N appears on rom_data_i in cycle N+1, which is
    // exactly when inflight_q is high, so capture needs no extra qualification.
    assign push      = inflight_q;
    assign pop       = (fifo_cnt_q != 2'd0) && out_ready_i;

    // Words already held plus the word in flight must fit in the 2-entry FIFO.
    // A pop this cycle frees a slot in time for the new read's data.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign credit    = (occupancy < 3'd2) || pop;

    // Add at full width, then keep the low ADDR_W bits to get the wrap.
    assign addr_sum  = {{LEN_W{1'b0}}, base_q} + {{ADDR_W{1'b0}}, issue_cnt_q};

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        issue_cnt_d   = issue_cnt_q;
        deliver_cnt_d = deliver_cnt_q + LEN_W'(pop);
        done_d        = 1'b0;
        issue         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d        = base_addr_i;
                    len_d         = length_i;
                    issue_cnt_d   = '0;
                    deliver_cnt_d = '0;
                    if (length_i != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (credit) begin
                    issue       = 1'b1;
                    issue_cnt_d = issue_cnt_q + LEN_W'(1);
                    if (issue_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final word lands at least two cycles after the last
                // issue. Once it is handshaken, no read is in flight and the
                // FIFO is empty.
                if (pop && (deliver_cnt_q == len_q - LEN_W'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issue_cnt_q   <= '0;
            deliver_cnt_q <= '0;
            done_q        <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            issue_cnt_q   <= issue_cnt_d;
            deliver_cnt_q <= deliver_cnt_d;
            done_q        <= done_d;
            inflight_q    <= issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= rom_data_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign en_o        = issue;
    assign address_o   = (state_q == S_ISSUE) ? addr_sum[ADDR_W-1:0] : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign out_valid_o = (fifo_cnt_q != 2'd0);
    assign out_data_o  = out_valid_o ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - self-checking bench for rom_burst_reader
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] base_addr = '0;
    logic [3:0] length = '0;
    logic       busy, done, en, out_valid;
    logic [2:0] address;
    logic [7:0] rom_data = '0;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;

    rom_burst_reader #(.ADDR_W(3), .DATA_W(8), .LEN_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .length_i    (length),
        .busy_o      (busy),
        .done_o      (done),
        .address_o   (address),
        .en_o        (en),
        .rom_data_i  (rom_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    // ROM model: word[a] = a + 1, registered output, holds when en is low.
    always @(posedge clk) if (en) rom_data <= 8'(address) + 8'd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the expected burst is simply the word list (base+i mod 8)+1.
    int         exp_q[$];
    logic [2:0] exp_addr;
    bit         mon_on = 0;
    bit         held_prev;
    logic [7:0] prev_data;
    int en_cnt, hs_cnt, done_cnt, first_en, last_en, first_valid, last_hs, done_rel;
    int ready_mode = 0;

    always @(negedge clk) begin
        int rel;
        if (mon_on) begin
            rel = cyc - t0;
            if (en) begin
                en_cnt++;
                if (first_en < 0) first_en = rel;
                last_en = rel;
                check("addr", address, exp_addr);
                exp_addr = exp_addr + 3'd1;
            end
            if (out_valid && held_prev) check("hold", out_data, prev_data);
            if (out_valid && first_valid < 0) first_valid = rel;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else check("data", out_data, exp_q.pop_front());
                hs_cnt++;
                last_hs = rel;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            held_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // mode: 0 ready=1, 1 random ready, 2 ready=0 until cycle release_at
    task automatic run_burst(input int b, input int l, input int mode,
                             input bit restart, input int release_at);
        en_cnt = 0; hs_cnt = 0; done_cnt = 0;
        first_en = -1; last_en = -1; first_valid = -1; last_hs = -1; done_rel = -1;
        exp_q.delete();
        for (int i = 0; i < l; i++) exp_q.push_back(((b + i) % 8) + 1);
        exp_addr = 3'(b);
        ready_mode = mode;
        if (mode == 0) out_ready = 1'b1;
        if (mode == 2) out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'(b); length = 4'(l);
        t0 = cyc; held_prev = 0; mon_on = 1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 3'($urandom); length = 4'($urandom);
        if (l != 0) check("busy_c1", busy, 1);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            start = restart && (cyc - t0 == 3);
            if (mode == 2 && cyc - t0 == release_at) begin
                check("bp_en_cnt", en_cnt, 2);
                check("bp_hold_data", out_data, (b % 8) + 1);
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (done_cnt == 0) check("timeout", 0, 1);
        ready_mode = 0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("en_cnt", en_cnt, l);
        check("hs_cnt", hs_cnt, l);
        check("words_left", exp_q.size(), 0);
        check("done_cnt", done_cnt, 1);
        check("busy_end", busy, 0);
        mon_on = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", address, 0);
        rst_n = 1'b1;

        // Full burst, no backpressure: exact cycle timing.
        run_burst(0, 8, 0, 0, 0);
        check("t_first_en", first_en, 1);
        check("t_last_en", last_en, 8);
        check("t_first_valid", first_valid, 3);
        check("t_last_hs", last_hs, 10);
        check("t_done", done_rel, 11);

        // Address wrap.
        run_burst(6, 4, 0, 0, 0);

        // Backpressure from start, released in cycle 10.
        run_burst(0, 8, 2, 0, 10);

        // Zero-length burst.
        run_burst(3, 0, 0, 0, 0);
        check("z_valid", first_valid, -1);
        check("z_done", done_rel, 1);

        // start while busy is ignored.
        run_burst(2, 5, 0, 1, 0);

        // Reset mid-burst.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'd0; length = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", en, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_addr", address, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_burst(5, 6, 0, 0, 0);

        // Randomized bursts with random backpressure.
        for (int n = 0; n < 25; n++) begin
            run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1,
                      1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
